// File: rtl/string_banner.sv
`default_nettype none
// ============================================================================
// Module   : string_banner
// Brief    : Multi-line, multi-message text overlay on the VGA bus with a
//            frame-timed typewriter reveal. Optional blink via the macro
//            STRING_BANNER_BLINK_EN (adds BLINK_ON_FRAMES / BLINK_OFF_FRAMES).
// Revision : 1.0 - initial release
// ============================================================================

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

// Bus layout: {hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk, rgb[11:0]}

// ----------------------------------------------------------------------------
// draw_rect_char: locates the current pixel inside the character grid and
// overlays the glyph bit returned by the font ROM one cycle later.
// ----------------------------------------------------------------------------
module draw_rect_char #(
    parameter logic [11:0] COLOUR    = 12'hFFF,
    parameter int          FONT_SIZE = 1,
    parameter int          POS_X     = 0,
    parameter int          POS_Y     = 0,
    parameter int          SIZE_X    = 16,
    parameter int          SIZE_Y    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_text_en,
    input  logic [7:0]               i_char_pixels,
    input  logic [`VGA_BUS_SIZE-1:0] i_vga_bus,
    output logic [`VGA_BUS_SIZE-1:0] o_vga_bus,
    output logic [7:0]               o_char_xy,
    output logic [3:0]               o_char_line
);
    localparam int c_hc_lsb = 27;
    localparam int c_vc_lsb = 14;
    localparam int c_shift  = FONT_SIZE - 1;
    localparam int c_box_w  = (SIZE_X * 8) << c_shift;
    localparam int c_box_h  = (SIZE_Y * 16) << c_shift;

    logic [10:0] w_hcount;
    logic [10:0] w_vcount;
    logic [10:0] w_rel_x;
    logic [10:0] w_rel_y;
    logic [10:0] w_sx;
    logic [10:0] w_sy;
    logic        w_in_box;
    logic        w_unused;

    logic [`VGA_BUS_SIZE-1:0] r_bus1;
    logic [`VGA_BUS_SIZE-1:0] r_bus2;
    logic                     r_draw1;
    logic                     r_draw2;
    logic [2:0]               r_col1;
    logic [2:0]               r_col2;

    assign w_hcount = i_vga_bus[c_hc_lsb +: 11];
    assign w_vcount = i_vga_bus[c_vc_lsb +: 11];
    assign w_rel_x  = w_hcount - 11'(POS_X);
    assign w_rel_y  = w_vcount - 11'(POS_Y);
    assign w_sx     = w_rel_x >> c_shift;
    assign w_sy     = w_rel_y >> c_shift;
    assign w_in_box = (int'(w_hcount) >= POS_X) && (int'(w_vcount) >= POS_Y) &&
                      (int'(w_rel_x) < c_box_w) && (int'(w_rel_y) < c_box_h);
    assign w_unused = ^{w_sx[10:7], w_sy[10:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus1      <= '0;
            r_bus2      <= '0;
            r_draw1     <= 1'b0;
            r_draw2     <= 1'b0;
            r_col1      <= '0;
            r_col2      <= '0;
            o_char_xy   <= '0;
            o_char_line <= '0;
            o_vga_bus   <= '0;
        end else begin
            r_bus1      <= i_vga_bus;
            r_draw1     <= i_text_en & w_in_box;
            r_col1      <= w_sx[2:0];
            o_char_xy   <= {w_sx[6:3], w_sy[7:4]};
            o_char_line <= w_sy[3:0];

            // Font data for stage-1 coordinates arrives alongside stage 2
            r_bus2  <= r_bus1;
            r_draw2 <= r_draw1;
            r_col2  <= r_col1;

            o_vga_bus <= r_bus2;
            if (r_draw2 && i_char_pixels[3'd7 - r_col2]) begin
                o_vga_bus[11:0] <= COLOUR;
            end
        end
    end
endmodule

// ----------------------------------------------------------------------------
// font_rom: compact built-in glyph set. Code 0x00 and space are blank; other
// codes render their 7-bit code with a leading set bit, top and bottom rows
// kept clear as inter-line spacing. Registered read.
// ----------------------------------------------------------------------------
module font_rom (
    input  logic        clk,
    input  logic [10:0] i_addr,
    output logic [7:0]  o_char_line_pixels
);
    logic [6:0] w_code;
    logic [3:0] w_line;

    assign w_code = i_addr[10:4];
    assign w_line = i_addr[3:0];

    always_ff @(posedge clk) begin
        if (w_code == 7'h00 || w_code == 7'h20 || w_line == 4'h0 || w_line == 4'hF) begin
            o_char_line_pixels <= 8'h00;
        end else begin
            o_char_line_pixels <= {1'b1, w_code};
        end
    end
endmodule

// ----------------------------------------------------------------------------
// string_banner: top level
// ----------------------------------------------------------------------------
module string_banner #(
    parameter logic [11:0] TEXT_COLOUR   = 12'hFFF,
    parameter int          FONT_SIZE     = 1,
    parameter int          TEXT_POS_X    = 0,
    parameter int          TEXT_POS_Y    = 0,
    parameter int          TEXT_SIZE_X   = 16,
    parameter int          TEXT_SIZE_Y   = 1,
    parameter int          MSG_COUNT     = 2,
    parameter int          MSG_SEL_W     = 1,
    parameter logic [MSG_COUNT*TEXT_SIZE_X*TEXT_SIZE_Y*8-1:0] MESSAGES =
        {(MSG_COUNT*TEXT_SIZE_X*TEXT_SIZE_Y){8'h20}},
    parameter int          REVEAL_FRAMES = 4
`ifdef STRING_BANNER_BLINK_EN
    ,
    parameter int          BLINK_ON_FRAMES  = 30,
    parameter int          BLINK_OFF_FRAMES = 30
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     module_en,
    input  logic [MSG_SEL_W-1:0]     msg_sel,
    input  logic                     restart,
    input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
    output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
    output logic                     reveal_done
);
    localparam int c_vsync_bit = 13;
    localparam int c_n         = TEXT_SIZE_X * TEXT_SIZE_Y;
    localparam int c_total     = MSG_COUNT * c_n;
    localparam int c_cnt_w     = $clog2(c_n + 1);
    localparam int c_fc_w      = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_n_cnt = c_cnt_w'(c_n);

    logic                 r_vsync_prev;
    logic                 r_frame_tick;
    logic                 r_en_prev;
    logic [MSG_SEL_W-1:0] r_act_msg;
    logic [c_fc_w-1:0]    r_frame_cnt;
    logic [c_cnt_w-1:0]   r_reveal_cnt;
    logic                 r_reveal_done;

    logic       w_load;
    logic       w_restart;
    logic       w_text_en;
    logic [7:0] w_char_xy;
    logic [3:0] w_char_line;
    logic [7:0] w_char_pixels;
    logic [6:0] w_char_code;
    int         w_idx;
    int         w_glob;

    assign w_load      = r_frame_tick && (int'(msg_sel) < MSG_COUNT);
    assign w_restart   = restart || (module_en && !r_en_prev) ||
                         (w_load && (msg_sel != r_act_msg));
    assign reveal_done = r_reveal_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_prev  <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_en_prev     <= 1'b0;
            r_act_msg     <= '0;
            r_frame_cnt   <= '0;
            r_reveal_cnt  <= '0;
            r_reveal_done <= 1'b0;
        end else begin
            r_vsync_prev  <= vga_bus_in[c_vsync_bit];
            r_frame_tick  <= vga_bus_in[c_vsync_bit] & ~r_vsync_prev;
            r_en_prev     <= module_en;
            r_reveal_done <= (r_reveal_cnt == c_n_cnt) && module_en;

            if (w_load) begin
                r_act_msg <= msg_sel;
            end

            // Restart takes priority over a coincident frame tick
            if (!module_en || w_restart) begin
                r_frame_cnt  <= '0;
                r_reveal_cnt <= '0;
            end else if (REVEAL_FRAMES == 0) begin
                r_reveal_cnt <= c_n_cnt;
            end else if (r_frame_tick) begin
                if (int'(r_frame_cnt) == REVEAL_FRAMES - 1) begin
                    r_frame_cnt <= '0;
                    if (r_reveal_cnt != c_n_cnt) begin
                        r_reveal_cnt <= r_reveal_cnt + c_cnt_w'(1);
                    end
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_fc_w'(1);
                end
            end
        end
    end

    // Characters past the reveal point render as the blank glyph
    always_comb begin
        w_char_code = 7'h00;
        w_idx       = 0;
        w_glob      = 0;
        if (int'(w_char_xy[7:4]) < TEXT_SIZE_X && int'(w_char_xy[3:0]) < TEXT_SIZE_Y) begin
            w_idx = int'(w_char_xy[3:0]) * TEXT_SIZE_X + int'(w_char_xy[7:4]);
            if (w_idx < int'(r_reveal_cnt)) begin
                w_glob      = int'(r_act_msg) * c_n + w_idx;
                w_char_code = MESSAGES[(c_total - 1 - w_glob) * 8 +: 7];
            end
        end
    end

`ifdef STRING_BANNER_BLINK_EN
    localparam int c_blink_max = (BLINK_ON_FRAMES > BLINK_OFF_FRAMES) ?
                                 BLINK_ON_FRAMES : BLINK_OFF_FRAMES;
    localparam int c_blink_w   = (c_blink_max > 1) ? $clog2(c_blink_max) : 1;

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_phase_on;

    // Text stays steady until the reveal completes, then alternates phases
    always_ff @(posedge clk) begin
        if (rst || w_restart || !r_reveal_done) begin
            r_phase_on  <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_frame_tick) begin
            if (r_phase_on) begin
                if (int'(r_blink_cnt) >= BLINK_ON_FRAMES - 1) begin
                    r_phase_on  <= 1'b0;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
                end
            end else begin
                if (int'(r_blink_cnt) >= BLINK_OFF_FRAMES - 1) begin
                    r_phase_on  <= 1'b1;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
                end
            end
        end
    end

    assign w_text_en = module_en & r_phase_on;
`else
    assign w_text_en = module_en;
`endif

    draw_rect_char #(
        .COLOUR    (TEXT_COLOUR),
        .FONT_SIZE (FONT_SIZE),
        .POS_X     (TEXT_POS_X),
        .POS_Y     (TEXT_POS_Y),
        .SIZE_X    (TEXT_SIZE_X),
        .SIZE_Y    (TEXT_SIZE_Y)
    ) u_draw_rect_char (
        .clk           (clk),
        .rst           (rst),
        .i_text_en     (w_text_en),
        .i_char_pixels (w_char_pixels),
        .i_vga_bus     (vga_bus_in),
        .o_vga_bus     (vga_bus_out),
        .o_char_xy     (w_char_xy),
        .o_char_line   (w_char_line)
    );

    font_rom u_font_rom (
        .clk                (clk),
        .i_addr             ({w_char_code, w_char_line}),
        .o_char_line_pixels (w_char_pixels)
    );
endmodule

`default_nettype wire

// File: tb/tb_string_banner.sv
`default_nettype none
// ============================================================================
// Module   : tb_string_banner
// Brief    : Self-checking bench for string_banner (4x2 chars, 2 messages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_string_banner;
    localparam int          W   = 38;
    localparam logic [11:0] COL = 12'hFFF;
    localparam int          PX  = 16;
    localparam int          PY  = 8;
    localparam int          SX  = 4;
    localparam int          SY  = 2;
    localparam int          RF  = 2;
    localparam int          N   = SX * SY;
    localparam int          LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         module_en;
    logic         restart;
    logic [1:0]   msg_sel;
    logic [W-1:0] vga_bus_in;
    logic [W-1:0] vga_bus_out;
    logic         reveal_done;

    string_banner #(
        .TEXT_COLOUR   (COL),
        .FONT_SIZE     (1),
        .TEXT_POS_X    (PX),
        .TEXT_POS_Y    (PY),
        .TEXT_SIZE_X   (SX),
        .TEXT_SIZE_Y   (SY),
        .MSG_COUNT     (2),
        .MSG_SEL_W     (2),
        .MESSAGES      ("ABCDEFGHwxyz1234"),
        .REVEAL_FRAMES (RF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .module_en   (module_en),
        .msg_sel     (msg_sel),
        .restart     (restart),
        .vga_bus_in  (vga_bus_in),
        .vga_bus_out (vga_bus_out),
        .reveal_done (reveal_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [W-1:0] exp;
        string        tag;
    } sb_t;

    typedef struct {
        int         x;
        int         y;
        int         line;
        logic [6:0] code;
        string      name;
    } vec_t;

    sb_t   sbq[$];
    vec_t  vecs[7];
    int    checks   = 0;
    int    failures = 0;

    // Reference model state
    string s_msgs = "ABCDEFGHwxyz1234";
    int    m_rev;
    int    m_fc;
    int    m_act;
    bit    m_en;

    always @(negedge clk) begin
        sb_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (e.due != cyc) begin
                failures++;
                $display("FAIL %s: output slot missed, due=%0d now=%0d", e.tag, e.due, cyc);
            end else if (vga_bus_out !== e.exp) begin
                failures++;
                $display("FAIL %s: vga_bus_out=%h expected=%h", e.tag, vga_bus_out, e.exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk_bus(input int hc, input int vc, input bit vs,
                                            input logic [11:0] rgb);
        logic [W-1:0] b;
        b        = '0;
        b[37:27] = 11'(hc);
        b[26]    = hc[0];
        b[24:14] = 11'(vc);
        b[13]    = vs;
        b[12]    = vc[0];
        b[11:0]  = rgb;
        return b;
    endfunction

    function automatic logic [6:0] model_code(input int x, input int y);
        byte c;
        int  idx;
        if (x >= SX || y >= SY) return 7'h00;
        idx = y * SX + x;
        if (idx >= m_rev) return 7'h00;
        c = s_msgs[m_act * N + idx];
        return c[6:0];
    endfunction

    function automatic logic [W-1:0] expect_px(input logic [W-1:0] b, input int line,
                                               input int col, input logic [6:0] code);
        logic [7:0]   g;
        logic [W-1:0] r;
        r = b;
        g = (code == 7'h00 || code == 7'h20 || line == 0 || line == 15) ? 8'h00 : {1'b1, code};
        if (m_en && g[7 - col]) r[11:0] = COL;
        return r;
    endfunction

    task automatic step(input logic [W-1:0] b, input logic [W-1:0] exp, input bit chk,
                        input string tag);
        vga_bus_in = b;
        if (chk) sbq.push_back('{cyc + LAT, exp, tag});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit vs, input bit chk);
        logic [W-1:0] b;
        b = mk_bus(0, 0, vs, 12'h3C3);
        step(b, b, chk, "idle_passthru");
    endtask

    task automatic model_tick();
        if (msg_sel < 2 && int'(msg_sel) != m_act) begin
            m_act = int'(msg_sel);
            m_rev = 0;
            m_fc  = 0;
        end else if (m_en) begin
            m_fc++;
            if (m_fc == RF) begin
                m_fc = 0;
                if (m_rev < N) m_rev++;
            end
        end
    endtask

    task automatic tick();
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        repeat (4) idle(1'b0, 1'b1);
        model_tick();
    endtask

    task automatic probe(input int x, input int y, input int line, input logic [6:0] code,
                         input string tag);
        logic [W-1:0] b;
        for (int c = 0; c < 8; c++) begin
            b = mk_bus(PX + x * 8 + c, PY + y * 16 + line, 1'b0, 12'(c * 17 + 5));
            step(b, expect_px(b, line, c, code), 1'b1, tag);
        end
    endtask

    task automatic probe_model(input int x, input int y, input int line, input string tag);
        probe(x, y, line, model_code(x, y), tag);
    endtask

    task automatic check_done(input bit exp, input string tag);
        checks++;
        if (reveal_done !== exp) begin
            failures++;
            $display("FAIL %s: reveal_done=%0b expected=%0b", tag, reveal_done, exp);
        end
    endtask

    task automatic check_out_zero(input string tag);
        checks++;
        if (vga_bus_out !== '0) begin
            failures++;
            $display("FAIL %s: vga_bus_out=%h expected=0", tag, vga_bus_out);
        end
    endtask

    initial begin
        vecs[0] = '{0, 0, 5,  7'h41, "full0_A"};
        vecs[1] = '{1, 0, 1,  7'h42, "full0_B"};
        vecs[2] = '{3, 0, 14, 7'h44, "full0_D"};
        vecs[3] = '{3, 1, 5,  7'h48, "xy31_H"};
        vecs[4] = '{2, 1, 0,  7'h00, "line0_blank"};
        vecs[5] = '{0, 1, 15, 7'h00, "line15_blank"};
        vecs[6] = '{1, 2, 5,  7'h00, "xy12_outside"};

        rst = 1'b1; module_en = 1'b0; restart = 1'b0; msg_sel = 2'd0;
        vga_bus_in = '0;
        m_rev = 0; m_fc = 0; m_act = 0; m_en = 1'b0;

        repeat (3) idle(1'b0, 1'b0);
        check_out_zero("reset_bus");
        check_done(1'b0, "reset_done");

        rst = 1'b0; module_en = 1'b1; m_en = 1'b1;
        repeat (3) idle(1'b0, 1'b1);
        probe_model(0, 0, 5, "pre_reveal_blank");
        check_done(1'b0, "pre_reveal_done");

        tick(); tick();
        probe_model(0, 0, 5, "tick2_idx0_A");
        probe_model(1, 0, 5, "tick2_idx1_blank");

        repeat (13) tick();
        check_done(1'b0, "tick15_not_done");
        probe_model(3, 1, 5, "tick15_idx7_blank");

        // 16th tick: reveal_cnt reaches N, reveal_done follows one cycle later
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check_done(1'b0, "tick16_done_latency");
        idle(1'b0, 1'b1);
        check_done(1'b1, "tick16_done");
        repeat (3) idle(1'b0, 1'b1);
        model_tick();

        foreach (vecs[i]) probe(vecs[i].x, vecs[i].y, vecs[i].line, vecs[i].code, vecs[i].name);

        // Message select only takes effect at a frame tick
        msg_sel = 2'd1;
        repeat (5) idle(1'b0, 1'b1);
        check_done(1'b1, "sel_midframe_done");
        probe_model(0, 0, 5, "sel_midframe_A");
        tick();
        check_done(1'b0, "sel_tick_restart");
        probe_model(0, 0, 5, "sel_tick_blank");
        repeat (16) tick();
        check_done(1'b1, "msg1_done");
        probe_model(0, 0, 5, "msg1_w");
        probe_model(3, 1, 5, "msg1_4");

        msg_sel = 2'd3;
        tick();
        check_done(1'b1, "sel3_hold_done");
        probe_model(1, 0, 5, "sel3_hold_x");
        msg_sel = 2'd1;

        // Restart coincident with the registered frame tick
        idle(1'b1, 1'b1);
        restart = 1'b1;
        idle(1'b1, 1'b1);
        restart = 1'b0;
        repeat (4) idle(1'b0, 1'b1);
        m_rev = 0; m_fc = 0;
        check_done(1'b0, "restart_tick_done");
        probe_model(0, 0, 5, "restart_tick_blank");
        tick(); tick();
        probe_model(0, 0, 5, "restart_then2_w");
        probe_model(1, 0, 5, "restart_then2_blank");

        // Disabled overlay passes the bus through
        module_en = 1'b0; m_en = 1'b0; m_rev = 0; m_fc = 0;
        repeat (3) idle(1'b0, 1'b1);
        check_done(1'b0, "disabled_done");
        probe(0, 0, 5, 7'h77, "disabled_passthru");
        tick();
        module_en = 1'b1; m_en = 1'b1;
        repeat (3) idle(1'b0, 1'b1);
        probe_model(0, 0, 5, "reenable_blank");
        tick(); tick();
        probe_model(0, 0, 5, "reenable_w");
        tick();

        // Reset in the middle of a reveal
        repeat (3) idle(1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) idle(1'b0, 1'b0);
        check_out_zero("midreset_bus");
        check_done(1'b0, "midreset_done");
        rst = 1'b0; msg_sel = 2'd3;
        m_act = 0; m_rev = 0; m_fc = 0;
        repeat (3) idle(1'b0, 1'b1);
        check_done(1'b0, "postreset_done");
        probe_model(0, 0, 5, "postreset_blank");
        tick(); tick();
        probe_model(0, 0, 5, "postreset_act0_A");

        repeat (LAT + 1) idle(1'b0, 1'b0);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
